// File: rtl/assoc_dcache.sv
// Set-associative write-back data cache with LRU ages.
// Halt flushes dirty lines, then writes the hit count out.
module assoc_dcache #(
    parameter int SETS = 8,
    parameter int WAYS = 2,
    parameter int WORDS = 2,
    parameter logic [31:0] HITADDR = 32'h0000_3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    input  logic        dwait,
    input  logic [31:0] dload,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore
);
    localparam int BW = $clog2(WORDS);
    localparam int IW = $clog2(SETS);
    localparam int WW = $clog2(WAYS);
    localparam int TW = 32 - 2 - BW - IW;
    localparam int LW = IW + WW;

    typedef enum logic [2:0] {IDLE, WB, LOAD, FLUSH, HITCNT, DONE} state_t;
    state_t state, nxt;

    logic          valid [SETS][WAYS];
    logic          dirty [SETS][WAYS];
    logic [TW-1:0] tags  [SETS][WAYS];
    logic [31:0]   data  [SETS][WAYS][WORDS];
    logic [WW-1:0] age   [SETS][WAYS];

    logic [31:0]   hitcnt;
    logic [BW-1:0] wcnt;
    logic [LW-1:0] lcnt;
    logic [WW-1:0] vic_q;
    logic [TW-1:0] rtag_q;
    logic [IW-1:0] ridx_q;

    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_idx;
    logic [BW-1:0] req_blk;
    logic          unused_bytoff;
    assign req_tag = dmemaddr[31 -: TW];
    assign req_idx = dmemaddr[2+BW +: IW];
    assign req_blk = dmemaddr[2 +: BW];
    assign unused_bytoff = ^dmemaddr[1:0];

    logic          req, req_go, hit_go, is_wr, hit, found;
    logic [WW-1:0] hit_way, vic_c;
    logic          last_w, last_l, fdirty;
    logic [IW-1:0] fset;
    logic [WW-1:0] fway;

    assign req    = dmemREN || dmemWEN;
    assign req_go = (state == IDLE) && !halt && req;
    assign hit_go = req_go && hit;
    assign is_wr  = !dmemREN && dmemWEN;
    assign last_w = (wcnt == BW'(WORDS - 1));
    assign last_l = (lcnt == LW'(SETS * WAYS - 1));
    assign fset   = lcnt[WW +: IW];
    assign fway   = lcnt[WW-1:0];
    assign fdirty = dirty[fset][fway];

    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[req_idx][w] && tags[req_idx][w] == req_tag) begin
                hit = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    // Invalid ways fill first; otherwise evict the oldest way.
    always_comb begin
        vic_c = '0;
        found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!valid[req_idx][w] && !found) begin
                vic_c = WW'(w);
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age[req_idx][w] >= age[req_idx][vic_c]) vic_c = WW'(w);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (halt) nxt = FLUSH;
                else if (req && !hit)
                    nxt = (valid[req_idx][vic_c] && dirty[req_idx][vic_c]) ? WB : LOAD;
            end
            WB:     if (!dwait && last_w) nxt = LOAD;
            LOAD:   if (!dwait && last_w) nxt = IDLE;
            FLUSH:  if ((!fdirty || (!dwait && last_w)) && last_l) nxt = HITCNT;
            HITCNT: if (!dwait) nxt = DONE;
            DONE:   nxt = DONE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        dhit = 1'b0;
        dmemload = '0;
        flushed = 1'b0;
        dREN = 1'b0;
        dWEN = 1'b0;
        daddr = '0;
        dstore = '0;
        unique case (state)
            IDLE: begin
                dhit = hit_go;
                if (hit_go && dmemREN) dmemload = data[req_idx][hit_way][req_blk];
            end
            WB: begin
                dWEN = 1'b1;
                daddr = {tags[ridx_q][vic_q], ridx_q, wcnt, 2'b00};
                dstore = data[ridx_q][vic_q][wcnt];
            end
            LOAD: begin
                dREN = 1'b1;
                daddr = {rtag_q, ridx_q, wcnt, 2'b00};
            end
            FLUSH: begin
                if (fdirty) begin
                    dWEN = 1'b1;
                    daddr = {tags[fset][fway], fset, wcnt, 2'b00};
                    dstore = data[fset][fway][wcnt];
                end
            end
            HITCNT: begin
                dWEN = 1'b1;
                daddr = HITADDR;
                dstore = hitcnt;
            end
            DONE: flushed = 1'b1;
            default: ;
        endcase
    end

    logic          touch_en;
    logic [IW-1:0] touch_set;
    logic [WW-1:0] touch_way;
    assign touch_en  = hit_go || (state == LOAD && !dwait && last_w);
    assign touch_set = (state == LOAD) ? ridx_q : req_idx;
    assign touch_way = (state == LOAD) ? vic_q : hit_way;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) age[s][w] <= WW'(w);
        end else if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WW'(w) == touch_way)
                    age[touch_set][w] <= '0;
                else if (age[touch_set][w] < age[touch_set][touch_way])
                    age[touch_set][w] <= age[touch_set][w] + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                    tags[s][w] <= '0;
                    for (int k = 0; k < WORDS; k++) data[s][w][k] <= '0;
                end
            end
            hitcnt <= '0;
            wcnt <= '0;
            lcnt <= '0;
            vic_q <= '0;
            rtag_q <= '0;
            ridx_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hit_go) begin
                        hitcnt <= hitcnt + 1'b1;
                        if (is_wr) begin
                            data[req_idx][hit_way][req_blk] <= dmemstore;
                            dirty[req_idx][hit_way] <= 1'b1;
                        end
                    end else if (req_go) begin
                        vic_q <= vic_c;
                        rtag_q <= req_tag;
                        ridx_q <= req_idx;
                        wcnt <= '0;
                    end
                end
                WB: if (!dwait) wcnt <= wcnt + 1'b1;
                LOAD: begin
                    if (!dwait) begin
                        data[ridx_q][vic_q][wcnt] <= dload;
                        wcnt <= wcnt + 1'b1;
                        if (last_w) begin
                            tags[ridx_q][vic_q] <= rtag_q;
                            valid[ridx_q][vic_q] <= 1'b1;
                            dirty[ridx_q][vic_q] <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (!fdirty) begin
                        lcnt <= lcnt + 1'b1;
                    end else if (!dwait) begin
                        wcnt <= wcnt + 1'b1;
                        if (last_w) begin
                            dirty[fset][fway] <= 1'b0;
                            lcnt <= lcnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_assoc_dcache.sv
// Randomized scoreboard bench for assoc_dcache against an
// LRU cache model with its own backing memory.
module tb_assoc_dcache;
    localparam int SETS = 8;
    localparam int WAYS = 2;
    localparam int WORDS = 2;
    localparam logic [31:0] HITADDR = 32'h0000_3100;
    localparam int BW = $clog2(WORDS);
    localparam int IW = $clog2(SETS);
    localparam int TW = 32 - 2 - BW - IW;

    logic CLK, nRST, halt, dmemREN, dmemWEN, dwait;
    logic [31:0] dmemaddr, dmemstore, dload;
    logic dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;

    assoc_dcache #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS), .HITADDR(HITADDR)) dut (
        .CLK(CLK), .nRST(nRST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
        .flushed(flushed), .dwait(dwait), .dload(dload), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    typedef struct packed {logic we; logic [31:0] a; logic [31:0] d;} beat_t;
    beat_t exp_bus[$];
    logic [31:0] exp_hit[$];

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] rd_slv(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] mk(input logic [TW-1:0] t, input int s, input int k);
        return {t, IW'(s), BW'(k), 2'b00};
    endfunction

    // Model: lines by set/way, LRU by last-use timestamp.
    bit          mv [SETS][WAYS];
    bit          md [SETS][WAYS];
    logic [TW-1:0] mt [SETS][WAYS];
    logic [31:0] mdat [SETS][WAYS][WORDS];
    int          stamp [SETS][WAYS];
    int          now;
    logic [31:0] hits;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                mv[s][w] = 0;
                md[s][w] = 0;
                mt[s][w] = '0;
                stamp[s][w] = WAYS - 1 - w;
            end
        now = WAYS;
        hits = 0;
    endtask

    task automatic model_req(input logic [31:0] a, input bit rd, input logic [31:0] wd);
        logic [TW-1:0] t;
        int s, b, hw, v;
        t = a[31 -: TW];
        s = int'(a[2+BW +: IW]);
        b = int'(a[2 +: BW]);
        hw = -1;
        for (int w = 0; w < WAYS; w++)
            if (mv[s][w] && mt[s][w] == t) hw = w;
        if (hw < 0) begin
            v = -1;
            for (int w = 0; w < WAYS; w++)
                if (!mv[s][w] && v < 0) v = w;
            if (v < 0) begin
                v = 0;
                for (int w = 1; w < WAYS; w++)
                    if (stamp[s][w] < stamp[s][v]) v = w;
            end
            if (mv[s][v] && md[s][v])
                for (int k = 0; k < WORDS; k++) begin
                    exp_bus.push_back({1'b1, mk(mt[s][v], s, k), mdat[s][v][k]});
                    ref_mem[mk(mt[s][v], s, k)] = mdat[s][v][k];
                end
            for (int k = 0; k < WORDS; k++) begin
                exp_bus.push_back({1'b0, mk(t, s, k), 32'h0});
                mdat[s][v][k] = rd_ref(mk(t, s, k));
            end
            mv[s][v] = 1;
            mt[s][v] = t;
            md[s][v] = 0;
            hw = v;
        end
        stamp[s][hw] = now;
        now++;
        if (rd) begin
            exp_hit.push_back(mdat[s][hw][b]);
        end else begin
            mdat[s][hw][b] = wd;
            md[s][hw] = 1;
            exp_hit.push_back(32'h0);
        end
        hits++;
    endtask

    task automatic model_flush();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (mv[s][w] && md[s][w]) begin
                    for (int k = 0; k < WORDS; k++) begin
                        exp_bus.push_back({1'b1, mk(mt[s][w], s, k), mdat[s][w][k]});
                        ref_mem[mk(mt[s][w], s, k)] = mdat[s][w][k];
                    end
                    md[s][w] = 0;
                end
        exp_bus.push_back({1'b1, HITADDR, hits});
    endtask

    bit rnd_wait = 0;
    always @(posedge CLK) begin
        #1;
        if (rnd_wait) dwait = ($urandom_range(0, 3) == 0);
    end

    always @(posedge CLK) begin
        #2;
        dload = rd_slv(daddr);
    end

    logic p_act, p_wait, p_ren, p_wen;
    logic [31:0] p_addr, p_st;
    beat_t eb;
    logic [31:0] eh;

    always @(negedge CLK) begin
        if (!nRST) begin
            p_act = 1'b0;
        end else begin
            if (dREN || dWEN) begin
                chk("rw_excl", 64'(dREN && dWEN), 64'd0);
                if (p_act && p_wait) begin
                    chk("hold_ctl", 64'({dREN, dWEN, daddr}), 64'({p_ren, p_wen, p_addr}));
                    chk("hold_data", 64'(dstore), 64'(p_st));
                end
                if (!dwait) begin
                    if (exp_bus.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL bus_extra: got we=%0d addr=%h want no beat", dWEN, daddr);
                    end else begin
                        eb = exp_bus.pop_front();
                        chk("bus_dir", 64'(dWEN), 64'(eb.we));
                        chk("bus_addr", 64'(daddr), 64'(eb.a));
                        if (dWEN) chk("bus_data", 64'(dstore), 64'(eb.d));
                    end
                    if (dWEN) slv_mem[daddr] = dstore;
                end
            end
            if (dhit) begin
                if (exp_hit.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL hit_extra: got dhit=1 want 0");
                end else begin
                    eh = exp_hit.pop_front();
                    chk("dmemload", 64'(dmemload), 64'(eh));
                end
            end
            p_act = dREN || dWEN;
            p_wait = dwait;
            p_ren = dREN;
            p_wen = dWEN;
            p_addr = daddr;
            p_st = dstore;
        end
    end

    task automatic do_req(input logic [31:0] a, input int op, input logic [31:0] wd);
        int n;
        model_req(a, op != 2, wd);
        dmemaddr = a;
        dmemstore = wd;
        dmemREN = (op != 2);
        dmemWEN = (op >= 2);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!dhit && n < 200);
        if (!dhit) begin
            total++;
            bad++;
            $display("FAIL req_timeout: got no dhit for %h want dhit", a);
            finish_run();
        end
        @(posedge CLK);
        #1;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, 64'({dhit, flushed, dREN, dWEN}), 64'd0);
        chk({nm, "_bus"}, {daddr, dstore}, 64'd0);
        chk({nm, "_load"}, 64'(dmemload), 64'd0);
    endtask

    initial begin
        int n;
        logic [TW-1:0] t;
        nRST = 1'b0;
        halt = 1'b0;
        dmemREN = 1'b1;
        dmemWEN = 1'b0;
        dmemaddr = 32'h40;
        dmemstore = '0;
        dwait = 1'b0;
        dload = '0;
        model_reset();
        repeat (2) @(negedge CLK);
        chk_zero("reset");
        dmemREN = 1'b0;
        @(posedge CLK);
        #1 nRST = 1'b1;

        do_req(32'h40, 0, 0);
        do_req(32'h44, 0, 0);
        rnd_wait = 1;
        for (int i = 0; i < 400; i++) begin
            t = TW'($urandom_range(0, 3));
            do_req(mk(t, $urandom_range(0, SETS - 1), $urandom_range(0, WORDS - 1)),
                   $urandom_range(0, 3), $urandom);
        end

        model_flush();
        halt = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!flushed && n < 5000);
        chk("flush_done", 64'(flushed), 64'd1);
        chk("flush_left", 64'(exp_bus.size()), 64'd0);
        chk("hit_left", 64'(exp_hit.size()), 64'd0);
        halt = 1'b0;
        dmemREN = 1'b1;
        dmemaddr = 32'h40;
        repeat (4) @(negedge CLK);
        chk("done_hold", 64'({flushed, dhit, dREN, dWEN}), 64'b1000);

        // Reset in the middle of a fill, then the same read must refill.
        @(negedge CLK);
        nRST = 1'b0;
        dmemREN = 1'b0;
        #1 chk_zero("rst_done");
        model_reset();
        @(posedge CLK);
        #1 nRST = 1'b1;
        rnd_wait = 0;
        dwait = 1'b0;
        exp_bus.push_back({1'b0, 32'h40, 32'h0});
        dmemaddr = 32'h40;
        dmemREN = 1'b1;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1 dwait = 1'b1;
        @(negedge CLK);
        nRST = 1'b0;
        #1 chk_zero("rst_load");
        chk("abort_q", 64'(exp_bus.size()), 64'd0);
        dmemREN = 1'b0;
        @(posedge CLK);
        #1 nRST = 1'b1;
        dwait = 1'b0;
        rnd_wait = 1;
        do_req(32'h40, 0, 0);
        do_req(32'h44, 0, 0);
        repeat (2) @(negedge CLK);
        chk("end_bus_q", 64'(exp_bus.size()), 64'd0);
        chk("end_hit_q", 64'(exp_hit.size()), 64'd0);
        finish_run();
    end
endmodule
